seven_seg_scanner: RTL and testbench

SEVEN_SEG_SCANNER -- requirements
Module: seven_seg_scanner

---
 rtl/seven_seg_scanner.sv | 160 ++++++++++++++++
 tb/tb_seven_seg_scanner.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A prescaler produces one tick per digit slot. The four digit codes and the
// overflow flag are captured once per frame, so a frame is always drawn from
// one consistent snapshot. While the overflow flag is set, the decimal point
// of digit 0 is lit and the whole display blinks with a period counted in
// frames.
module seven_seg_scanner #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned LZB          = 0
) (
    input  logic       sys_clk,
    input  logic       reset,
    input  logic [4:0] bcd3,
    input  logic [4:0] bcd2,
    input  logic [4:0] bcd1,
    input  logic [4:0] bcd0,
    input  logic       si,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned FC_W  = (BLINK_FRAMES > 2) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [FC_W-1:0]  FC_LAST    = FC_W'(BLINK_FRAMES - 1);
    localparam logic [4:0]       CODE_BLANK = 5'h10;
    localparam logic [6:0]       SEG_BLANK  = 7'h7F;

    // Code to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] seg_decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'd0:    s = 7'h40;
            5'd1:    s = 7'h79;
            5'd2:    s = 7'h24;
            5'd3:    s = 7'h30;
            5'd4:    s = 7'h19;
            5'd5:    s = 7'h12;
            5'd6:    s = 7'h02;
            5'd7:    s = 7'h78;
            5'd8:    s = 7'h00;
            5'd9:    s = 7'h10;
            5'h1F:   s = 7'h77;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

    // State
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0][4:0]  sh_q, sh_d;
    logic             si_q, si_d;
    logic [FC_W-1:0]  fc_q, fc_d;
    logic             blink_q, blink_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;

    logic       tick;
    logic       frame_end;
    logic [3:0] lz;
    logic [3:0] sel_onehot;
    logic [4:0] code_sel;

    assign tick      = (cnt_q == CNT_LAST);
    assign frame_end = tick && (ptr_q == 2'd3);

    // Prescaler, digit pointer, snapshot capture and blink bookkeeping
    always_comb begin
        cnt_d   = tick ? '0 : cnt_q + CNT_W'(1);
        ptr_d   = ptr_q;
        sh_d    = sh_q;
        si_d    = si_q;
        fc_d    = fc_q;
        blink_d = blink_q;
        if (tick) begin
            ptr_d = ptr_q + 2'd1;
        end
        if (frame_end) begin
            sh_d = {bcd3, bcd2, bcd1, bcd0};
            si_d = si;
            if (!si) begin
                // Overflow gone: blanking ends with the frame that starts now
                fc_d    = '0;
                blink_d = 1'b0;
            end else if (si_q) begin
                // Count only frames that were drawn with the flag already set
                if (fc_q == FC_LAST) begin
                    fc_d    = '0;
                    blink_d = ~blink_q;
                end else begin
                    fc_d = fc_q + FC_W'(1);
                end
            end
        end
    end

    // Leading-zero detection on the snapshot that the next slot will show
    always_comb begin
        lz    = 4'b0000;
        lz[3] = (sh_d[3] == 5'd0);
        lz[2] = lz[3] && (sh_d[2] == 5'd0);
        lz[1] = lz[2] && (sh_d[1] == 5'd0);
        lz[0] = 1'b0;
    end

    // Output values for the slot that begins at the next tick edge
    always_comb begin
        code_sel   = sh_d[ptr_d];
        sel_onehot = 4'b0001 << ptr_d;
        an_d       = blink_d ? 4'hF : ~sel_onehot;
        if ((LZB != 0) && lz[ptr_d]) begin
            seg_d = SEG_BLANK;
        end else begin
            seg_d = seg_decode(code_sel);
        end
        dp_d = !((ptr_d == 2'd0) && si_d && !blink_d);
    end

    // Scan state registers
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            ptr_q   <= 2'd3;
            sh_q    <= {4{CODE_BLANK}};
            si_q    <= 1'b0;
            fc_q    <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sh_q    <= sh_d;
            si_q    <= si_d;
            fc_q    <= fc_d;
            blink_q <= blink_d;
        end
    end

    // Registered display outputs, refreshed only on slot boundaries
    always_ff @(posedge sys_clk or negedge reset) begin
        if (!reset) begin
            an_q  <= 4'hF;
            seg_q <= SEG_BLANK;
            dp_q  <= 1'b1;
        end else if (tick) begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign an  = an_q;
    assign seg = seg_q;
    assign dp  = dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner with REFRESH_DIV=4, BLINK_FRAMES=2.
// Two instances share the stimulus: one without and one with leading-zero
// blanking. Outputs are sampled 1 time unit after the rising edge.
module tb_seven_seg_scanner;

    logic       sys_clk = 1'b0;
    logic       reset   = 1'b0;
    logic [4:0] bcd3, bcd2, bcd1, bcd0;
    logic       si;
    logic [3:0] an0, an1;
    logic [6:0] seg0, seg1;
    logic       dp0, dp1;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [11:0] RST_STATE = {4'hF, 7'h7F, 1'b1};
    localparam logic [11:0] M_ALL     = 12'hFFF;
    localparam logic [11:0] M_BLINK   = 12'hF01;

    always #5 sys_clk = ~sys_clk;

    seven_seg_scanner #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2),
        .LZB         (0)
    ) dut0 (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bcd3   (bcd3),
        .bcd2   (bcd2),
        .bcd1   (bcd1),
        .bcd0   (bcd0),
        .si     (si),
        .an     (an0),
        .seg    (seg0),
        .dp     (dp0)
    );

    seven_seg_scanner #(
        .REFRESH_DIV (4),
        .BLINK_FRAMES(2),
        .LZB         (1)
    ) dut1 (
        .sys_clk(sys_clk),
        .reset  (reset),
        .bcd3   (bcd3),
        .bcd2   (bcd2),
        .bcd1   (bcd1),
        .bcd0   (bcd0),
        .si     (si),
        .an     (an1),
        .seg    (seg1),
        .dp     (dp1)
    );

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp,
                       input logic [11:0] mask);
        vectors++;
        assert ((obs & mask) === (exp & mask)) else begin
            miscompares++;
            $error("FAIL %s: an/seg/dp got %h/%h/%b want %h/%h/%b (mask %h)", tag,
                   obs[11:8], obs[7:1], obs[0], exp[11:8], exp[7:1], exp[0], mask);
        end
    endtask

    task automatic step_tick();
        repeat (4) @(posedge sys_clk);
        #1;
    endtask

    initial begin
        logic [3:0]  oh;
        logic [11:0] exp;
        logic        blk;

        bcd3 = 5'd1; bcd2 = 5'd2; bcd1 = 5'd3; bcd0 = 5'd4; si = 1'b0;

        // Reset state
        #12;
        chk("reset_dut0", {an0, seg0, dp0}, RST_STATE, M_ALL);
        chk("reset_dut1", {an1, seg1, dp1}, RST_STATE, M_ALL);

        // Release; outputs hold until the first tick 4 cycles later
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("hold_before_tick", {an0, seg0, dp0}, RST_STATE, M_ALL);
        @(posedge sys_clk);
        #1;
        chk("f0_d0", {an0, seg0, dp0}, {4'hE, 7'h19, 1'b1}, M_ALL);
        step_tick();
        chk("f0_d1", {an0, seg0, dp0}, {4'hD, 7'h30, 1'b1}, M_ALL);
        step_tick();
        chk("f0_d2", {an0, seg0, dp0}, {4'hB, 7'h24, 1'b1}, M_ALL);

        // Mid-frame input change must wait for the next frame
        bcd0 = 5'd7;
        step_tick();
        chk("f0_d3", {an0, seg0, dp0}, {4'h7, 7'h79, 1'b1}, M_ALL);
        step_tick();
        chk("f1_d0_new", {an0, seg0, dp0}, {4'hE, 7'h78, 1'b1}, M_ALL);
        step_tick();
        chk("f1_d1", {an0, seg0, dp0}, {4'hD, 7'h30, 1'b1}, M_ALL);
        step_tick();
        chk("f1_d2", {an0, seg0, dp0}, {4'hB, 7'h24, 1'b1}, M_ALL);
        step_tick();
        chk("f1_d3", {an0, seg0, dp0}, {4'h7, 7'h79, 1'b1}, M_ALL);

        // Leading zeros and underscore, with and without blanking
        bcd3 = 5'd0; bcd2 = 5'd0; bcd1 = 5'd5; bcd0 = 5'h1F;
        step_tick();
        chk("lz0_d0", {an0, seg0, dp0}, {4'hE, 7'h77, 1'b1}, M_ALL);
        chk("lz1_d0", {an1, seg1, dp1}, {4'hE, 7'h77, 1'b1}, M_ALL);
        step_tick();
        chk("lz0_d1", {an0, seg0, dp0}, {4'hD, 7'h12, 1'b1}, M_ALL);
        chk("lz1_d1", {an1, seg1, dp1}, {4'hD, 7'h12, 1'b1}, M_ALL);
        step_tick();
        chk("lz0_d2", {an0, seg0, dp0}, {4'hB, 7'h40, 1'b1}, M_ALL);
        chk("lz1_d2", {an1, seg1, dp1}, {4'hB, 7'h7F, 1'b1}, M_ALL);
        step_tick();
        chk("lz0_d3", {an0, seg0, dp0}, {4'h7, 7'h40, 1'b1}, M_ALL);
        chk("lz1_d3", {an1, seg1, dp1}, {4'h7, 7'h7F, 1'b1}, M_ALL);

        // Overflow: dp on digit 0, blank in frames 2,3 of every 4 after the latch
        bcd3 = 5'd8; bcd2 = 5'd8; bcd1 = 5'd8; bcd0 = 5'd8; si = 1'b1;
        for (int f = 0; f < 7; f++) begin
            for (int d = 0; d < 4; d++) begin
                step_tick();
                blk = ((f % 4) == 2) || ((f % 4) == 3);
                oh  = 4'b0001 << d;
                if (blk) begin
                    chk($sformatf("ovf_f%0d_d%0d", f, d), {an0, seg0, dp0},
                        {4'hF, 7'h7F, 1'b1}, M_BLINK);
                end else begin
                    exp = {~oh, 7'h00, (d != 0)};
                    chk($sformatf("ovf_f%0d_d%0d", f, d), {an0, seg0, dp0}, exp, M_ALL);
                end
                if (f == 6 && d == 0) si = 1'b0;
            end
        end

        // Flag dropped during a blanked frame: next frame is shown, dp off
        step_tick();
        chk("ovf_stop_d0", {an0, seg0, dp0}, {4'hE, 7'h00, 1'b1}, M_ALL);
        step_tick();
        chk("ovf_stop_d1", {an0, seg0, dp0}, {4'hD, 7'h00, 1'b1}, M_ALL);

        // Mid-frame reset pulse
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        reset = 1'b0;
        #1;
        chk("midreset_dut0", {an0, seg0, dp0}, RST_STATE, M_ALL);
        chk("midreset_dut1", {an1, seg1, dp1}, RST_STATE, M_ALL);
        @(negedge sys_clk);
        reset = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("midreset_hold", {an0, seg0, dp0}, RST_STATE, M_ALL);
        @(posedge sys_clk);
        #1;
        chk("restart_dut0", {an0, seg0, dp0}, {4'hE, 7'h00, 1'b1}, M_ALL);
        chk("restart_dut1", {an1, seg1, dp1}, {4'hE, 7'h00, 1'b1}, M_ALL);
        step_tick();
        chk("restart_d1", {an0, seg0, dp0}, {4'hD, 7'h00, 1'b1}, M_ALL);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
